// File: rtl/tone_sequencer_if.sv
// Bundles the control inputs and the ROM/DAC-side outputs of the tone sequencer.
//   master : the enable source. It drives ENABLE, MODE and TONE_INC, and observes the outputs.
//   slave  : the sequencer. It consumes the controls and drives ADDR, TONE_IDX, ACTIVE and DONE.
interface tone_sequencer_if #(
  parameter int NUM_TONES = 3,
  parameter int ACC_W     = 24,
  parameter int ADDR_W    = 8
);
  localparam int IDX_W = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;

  logic                       ENABLE;
  logic                       MODE;
  logic [NUM_TONES*ACC_W-1:0] TONE_INC;
  logic [ADDR_W-1:0]          ADDR;
  logic [IDX_W-1:0]           TONE_IDX;
  logic                       ACTIVE;
  logic                       DONE;

  modport master (output ENABLE, MODE, TONE_INC,
                  input  ADDR, TONE_IDX, ACTIVE, DONE);
  modport slave  (input  ENABLE, MODE, TONE_INC,
                  output ADDR, TONE_IDX, ACTIVE, DONE);
endinterface

// File: rtl/tone_sequencer.sv
// DDS tone sequencer. It steps through NUM_TONES tones, each for TONE_TICKS cycles.
// An optional silent gap of GAP_TICKS cycles follows each tone.
// The sequence either loops forever or plays once (one-shot).
//   CLOCK   : system clock
//   RESET_N : asynchronous active-low reset
//   bus     : ENABLE/MODE/TONE_INC in; ADDR (sine ROM address), TONE_IDX,
//             ACTIVE (DAC unmute) and DONE (one-shot end pulse) out
// Every output comes from a register or is decoded from one.
module tone_sequencer #(
  parameter int NUM_TONES  = 3,
  parameter int ACC_W      = 24,
  parameter int ADDR_W     = 8,
  parameter int TONE_TICKS = 25000000,
  parameter int GAP_TICKS  = 0,
  parameter int DUR_W      = 26
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  tone_sequencer_if.slave   bus
);
  localparam int IDX_W = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [DUR_W-1:0] TONE_LAST = DUR_W'(TONE_TICKS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_TONES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic [NUM_TONES-1:0][ACC_W-1:0] inc_a;
  logic [ACC_W-1:0]                cur_inc;
  logic                            adv;

  assign inc_a = bus.TONE_INC;

  // Explicit compare-mux so that an index beyond NUM_TONES-1 can never select past the vector.
  always_comb begin
    cur_inc = '0;
    for (int i = 0; i < NUM_TONES; i++)
      if (idx_q == IDX_W'(i)) cur_inc = inc_a[i];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dur_d   = dur_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        dur_d = '0;
        idx_d = '0;
        if (bus.ENABLE) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (!bus.ENABLE) begin
          state_d = S_IDLE;
          acc_d   = '0;
          dur_d   = '0;
          idx_d   = '0;
        end else begin
          // The accumulator keeps running across tone changes so that the waveform stays continuous.
          acc_d = acc_q + cur_inc;
          if (dur_q == TONE_LAST) begin
            dur_d = '0;
            if (GAP_TICKS > 0) state_d = S_GAP;
            else               adv     = 1'b1;
          end else begin
            dur_d = dur_q + DUR_ONE;
          end
        end
      end
      S_GAP: begin
        if (!bus.ENABLE) begin
          state_d = S_IDLE;
          acc_d   = '0;
          dur_d   = '0;
          idx_d   = '0;
        end else if (dur_q == GAP_LAST) begin
          dur_d = '0;
          adv   = 1'b1;
        end else begin
          dur_d = dur_q + DUR_ONE;
        end
      end
      default: begin  // S_HOLD: wait for ENABLE to drop before re-arming
        if (!bus.ENABLE) begin
          state_d = S_IDLE;
          acc_d   = '0;
          dur_d   = '0;
          idx_d   = '0;
        end
      end
    endcase

    // MODE is only looked at here, when the last tone finishes.
    if (adv) begin
      if (idx_q != IDX_LAST) begin
        idx_d   = idx_q + IDX_ONE;
        state_d = S_PLAY;
      end else if (bus.MODE) begin
        idx_d   = '0;
        state_d = S_PLAY;
      end else begin
        state_d = S_HOLD;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      dur_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign bus.ADDR     = acc_q[ACC_W-1 -: ADDR_W];
  assign bus.TONE_IDX = idx_q;
  assign bus.ACTIVE   = (state_q == S_PLAY);
  assign bus.DONE     = done_q;
endmodule
